bout_controller: RTL and testbench

- Match-level sequencer above the attack/scoring datapath: gates the action FSM, applies the touch lockout window, awards touches and keeps score.
- Sequences the pre-bout countdown, the inter-touch pauses and match end; emits a round-reset pulse that re-arms the action FSM and the location/sync path.
- Consumes the per-frame scoring flags (player/opponent scored + data-valid strobe).
- Drives the display/HUD with scores, winner and state.

---
 rtl/bout_controller.sv | 198 +++++++++++++++++++
 tb/tb_bout_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bout_controller.sv
// Bout controller: match-level sequencer for touches, lockout and score.
// Gates the action FSM, awards touches and drives the HUD state.
module bout_controller #(
  parameter int unsigned LOCKOUT_CYCLES = 2970000,
  parameter int unsigned PAUSE_CYCLES   = 74250000,
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned SCORE_W        = 4
) (
  input  logic               clk_pixel_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic               hits_valid_in,
  input  logic               player_hit_in,
  input  logic               opponent_hit_in,
  output logic               fsm_enable_out,
  output logic               round_reset_out,
  output logic [SCORE_W-1:0] player_score_out,
  output logic [SCORE_W-1:0] opponent_score_out,
  output logic [1:0]         winner_out,
  output logic [2:0]         state_out
);

  localparam int unsigned MAX_CYC =
    (LOCKOUT_CYCLES > PAUSE_CYCLES) ?
    LOCKOUT_CYCLES : PAUSE_CYCLES;

  // Counter counts down from N-1 to 0, so it only
  // needs to hold MAX_CYC-1.
  localparam int unsigned CNT_W =
    (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOCK_LD =
    CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LD =
    CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE =
    SCORE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FENCE      = 3'd2,
    S_LOCKOUT    = 3'd3,
    S_AWARD      = 3'd4,
    S_PAUSE      = 3'd5,
    S_MATCH_OVER = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] p_score_q, p_score_d;
  logic [SCORE_W-1:0] o_score_q, o_score_d;
  logic [1:0]         winner_q, winner_d;
  logic               p_lat_q, p_lat_d;
  logic               o_lat_q, o_lat_d;
  logic               rr_q, rr_d;
  logic               en_q, en_d;

  logic               hit;
  logic               cnt_done;
  logic [SCORE_W-1:0] p_inc;
  logic [SCORE_W-1:0] o_inc;
  logic               p_won;
  logic               o_won;

  // Hit qualification and saturating score candidates.
  always_comb begin
    hit = hits_valid_in &
          (player_hit_in | opponent_hit_in);
    cnt_done = (cnt_q == '0);
    p_inc = p_score_q;
    o_inc = o_score_q;
    if (p_lat_q && (p_score_q < WIN)) begin
      p_inc = p_score_q + ONE;
    end
    if (o_lat_q && (o_score_q < WIN)) begin
      o_inc = o_score_q + ONE;
    end
    p_won = (p_inc == WIN);
    o_won = (o_inc == WIN);
  end

  // Next-state and next-output logic for the match sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_score_d = p_score_q;
    o_score_d = o_score_q;
    winner_d  = winner_q;
    p_lat_d   = p_lat_q;
    o_lat_d   = o_lat_q;
    rr_d      = 1'b0;

    unique case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start_in) begin
          state_d   = S_COUNTDOWN;
          cnt_d     = PAUSE_LD;
          p_score_d = '0;
          o_score_d = '0;
          winner_d  = 2'b00;
          p_lat_d   = 1'b0;
          o_lat_d   = 1'b0;
          rr_d      = 1'b1;
        end
      end

      S_COUNTDOWN, S_PAUSE: begin
        if (cnt_done) begin
          state_d = S_FENCE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FENCE: begin
        if (hit) begin
          state_d = S_LOCKOUT;
          cnt_d   = LOCK_LD;
          p_lat_d = player_hit_in;
          o_lat_d = opponent_hit_in;
        end
      end

      S_LOCKOUT: begin
        if (hits_valid_in) begin
          p_lat_d = p_lat_q | player_hit_in;
          o_lat_d = o_lat_q | opponent_hit_in;
        end
        if (cnt_done) begin
          state_d = S_AWARD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_AWARD: begin
        p_score_d = p_inc;
        o_score_d = o_inc;
        p_lat_d   = 1'b0;
        o_lat_d   = 1'b0;
        if (p_won || o_won) begin
          state_d  = S_MATCH_OVER;
          winner_d = {o_won, p_won};
        end else begin
          state_d = S_PAUSE;
          cnt_d   = PAUSE_LD;
          rr_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        p_lat_d = 1'b0;
        o_lat_d = 1'b0;
      end
    endcase

    en_d = (state_d == S_FENCE) ||
           (state_d == S_LOCKOUT);
  end

  // State, counter, scores and registered outputs.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_score_q <= '0;
      o_score_q <= '0;
      winner_q  <= 2'b00;
      p_lat_q   <= 1'b0;
      o_lat_q   <= 1'b0;
      rr_q      <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_score_q <= p_score_d;
      o_score_q <= o_score_d;
      winner_q  <= winner_d;
      p_lat_q   <= p_lat_d;
      o_lat_q   <= o_lat_d;
      rr_q      <= rr_d;
      en_q      <= en_d;
    end
  end

  assign fsm_enable_out     = en_q;
  assign round_reset_out    = rr_q;
  assign player_score_out   = p_score_q;
  assign opponent_score_out = o_score_q;
  assign winner_out         = winner_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_bout_controller.sv
// Bench for bout_controller: scoreboard of expected state entries.
// Stimulus pushes expectations; a negedge monitor pops on state changes.
module tb_bout_controller;

  localparam int LC = 4;
  localparam int PC = 8;
  localparam int WS = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          hv = 1'b0;
  logic          ph = 1'b0;
  logic          oh = 1'b0;
  logic          en;
  logic          rr;
  logic [SW-1:0] ps;
  logic [SW-1:0] os;
  logic [1:0]    win;
  logic [2:0]    st;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    st;
    logic [SW-1:0] ps;
    logic [SW-1:0] os;
    logic [1:0]    win;
    logic          en;
    logic          rr;
    int            dwell;
  } exp_t;

  exp_t exp_q[$];

  bit         mon_on = 1'b0;
  logic [2:0] last_st = 3'd0;
  int         dwell = 0;

  bout_controller #(
    .LOCKOUT_CYCLES(LC),
    .PAUSE_CYCLES(PC),
    .WIN_SCORE(WS),
    .SCORE_W(SW)
  ) dut (
    .clk_pixel_in(clk),
    .rst_n_in(rst_n),
    .start_in(start),
    .hits_valid_in(hv),
    .player_hit_in(ph),
    .opponent_hit_in(oh),
    .fsm_enable_out(en),
    .round_reset_out(rr),
    .player_score_out(ps),
    .opponent_score_out(os),
    .winner_out(win),
    .state_out(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic push(input logic [2:0] s,
                      input int p, input int o,
                      input int w, input bit e,
                      input bit r, input int d);
    exp_t x;
    x.st = s;
    x.ps = SW'(p);
    x.os = SW'(o);
    x.win = 2'(w);
    x.en = e;
    x.rr = r;
    x.dwell = d;
    exp_q.push_back(x);
  endtask

  // Monitor: pop and compare on every state change.
  always @(negedge clk) begin
    if (mon_on) begin
      if (st !== last_st) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry got %0d want none",
                   st);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("state", int'(st), int'(e.st));
          chk("player_score", int'(ps), int'(e.ps));
          chk("opp_score", int'(os), int'(e.os));
          chk("winner", int'(win), int'(e.win));
          chk("fsm_enable", int'(en), int'(e.en));
          chk("round_reset_entry", int'(rr), int'(e.rr));
          if (e.dwell != 0)
            chk("dwell", dwell, e.dwell);
        end
        last_st = st;
        dwell = 1;
      end else begin
        dwell++;
        chk("round_reset_idle", int'(rr), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int lim);
    int n;
    n = 0;
    while (st !== s && n < lim) begin
      tick();
      n++;
    end
    chk("wait_state", int'(st), int'(s));
  endtask

  task automatic clr_hits();
    hv = 1'b0;
    ph = 1'b0;
    oh = 1'b0;
  endtask

  // First hit, then an optional second hit off cycles later.
  task automatic hit_seq(input bit p0, input bit o0,
                         input int off,
                         input bit p1, input bit o1);
    hv = 1'b1;
    ph = p0;
    oh = o0;
    tick();
    clr_hits();
    if (off > 0) begin
      for (int k = 1; k < off; k++) tick();
      hv = 1'b1;
      ph = p1;
      oh = o1;
      tick();
      clr_hits();
    end
  endtask

  task automatic do_start();
    push(3'd1, 0, 0, 0, 1'b0, 1'b1, 0);
    push(3'd2, 0, 0, 0, 1'b1, 1'b0, PC);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expectations for one touch that continues the match.
  task automatic exp_cont(input int p, input int o,
                          input int np, input int no);
    push(3'd3, p, o, 0, 1'b1, 1'b0, 0);
    push(3'd4, p, o, 0, 1'b0, 1'b0, LC);
    push(3'd5, np, no, 0, 1'b0, 1'b1, 1);
    push(3'd2, np, no, 0, 1'b1, 1'b0, PC);
  endtask

  // Expectations for one touch that ends the match.
  task automatic exp_end(input int p, input int o,
                         input int np, input int no,
                         input int w);
    push(3'd3, p, o, 0, 1'b1, 1'b0, 0);
    push(3'd4, p, o, 0, 1'b0, 1'b0, LC);
    push(3'd6, np, no, w, 1'b0, 1'b0, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_state", int'(st), 0);
    chk("reset_pscore", int'(ps), 0);
    chk("reset_oscore", int'(os), 0);
    chk("reset_winner", int'(win), 0);
    chk("reset_enable", int'(en), 0);
    chk("reset_rr", int'(rr), 0);
    mon_on = 1'b1;

    // Match A: countdown hits ignored, masking, normal touch.
    do_start();
    hv = 1'b1;
    ph = 1'b1;
    oh = 1'b1;
    repeat (3) tick();
    clr_hits();
    wait_state(3'd2, 30);

    hv = 1'b0;
    ph = 1'b1;
    oh = 1'b1;
    repeat (3) tick();
    clr_hits();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mask_state", int'(st), 2);
    chk("mask_pscore", int'(ps), 0);
    chk("mask_oscore", int'(os), 0);

    exp_cont(0, 0, 1, 0);
    hit_seq(1'b1, 1'b0, 0, 1'b0, 1'b0);
    wait_state(3'd5, 20);
    hv = 1'b1;
    ph = 1'b1;
    oh = 1'b1;
    repeat (3) tick();
    clr_hits();
    wait_state(3'd2, 30);
    chk("pause_hits_oscore", int'(os), 0);

    // Late opponent hit (AWARD cycle) is not credited.
    exp_end(1, 0, 2, 0, 1);
    hit_seq(1'b1, 1'b0, 5, 1'b0, 1'b1);
    wait_state(3'd6, 20);
    chk("late_oscore", int'(os), 0);
    chk("late_winner", int'(win), 1);

    // Match B: double touch inside lockout, then simultaneous win.
    do_start();
    wait_state(3'd2, 30);
    exp_cont(0, 0, 1, 1);
    hit_seq(1'b1, 1'b0, 2, 1'b0, 1'b1);
    wait_state(3'd5, 20);
    wait_state(3'd2, 30);
    exp_end(1, 1, 2, 2, 3);
    hit_seq(1'b1, 1'b1, 0, 1'b0, 1'b0);
    wait_state(3'd6, 20);
    chk("simul_winner", int'(win), 3);

    // Match C: hit on last lockout cycle counts, then player win.
    do_start();
    wait_state(3'd2, 30);
    exp_cont(0, 0, 1, 1);
    hit_seq(1'b1, 1'b0, 4, 1'b0, 1'b1);
    wait_state(3'd5, 20);
    wait_state(3'd2, 30);
    exp_end(1, 1, 2, 1, 1);
    hit_seq(1'b1, 1'b0, 0, 1'b0, 1'b0);
    wait_state(3'd6, 20);
    chk("pwin_enable", int'(en), 0);

    // Match D: reset in the middle of lockout.
    do_start();
    wait_state(3'd2, 30);
    push(3'd3, 0, 0, 0, 1'b1, 1'b0, 0);
    push(3'd0, 0, 0, 0, 1'b0, 1'b0, 0);
    hit_seq(1'b0, 1'b1, 0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(st), 0);
    chk("midrst_enable", int'(en), 0);
    chk("midrst_oscore", int'(os), 0);
    chk("midrst_winner", int'(win), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midrst_hold", int'(st), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1);
  end

endmodule
